// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Pipeline hazard unit for a classic 5-stage in-order core. It decides when
//   the front end stalls (load-use and ID-resolved branch operand hazards),
//   when the whole back end freezes on a slow data-memory access, and when
//   IF/ID is flushed after a taken branch or jump. A flush that arrives during
//   a memory freeze is remembered and applied on the first unfrozen cycle.
//
// Ports
//   clk, rst                        clock, async active-low reset
//   Rs, Rt, UseRs, UseRt            source specifiers of the ID instruction
//   Branch, BranchNot               ID instruction is beq / bne
//   ID_EX_MemRead, ID_EX_RegWrite,
//   ID_EX_RegisterRd                ID/EX control and destination
//   EX_MEM_MemRead, EX_MEM_MemWrite,
//   EX_MEM_RegisterRd               EX/MEM control and destination
//   mem_ready                       data memory finishes its access this cycle
//   branch_taken                    resolved branch/jump is taken
//   PCWrite, IF_ID_Write            PC and IF/ID enables
//   Sel                             0 = inject a bubble into ID/EX
//   pipe_hold                       freeze ID/EX, EX/MEM, MEM/WB
//   IF_ID_Flush                     clear IF/ID
//   mem_err                         one-cycle pulse on memory timeout
//   stall_count                     saturating count of PCWrite=0 cycles
// -----------------------------------------------------------------------------

// Per-source operand matcher: one instance per ID source register.
// Register 0 is hardwired zero, so it never creates a dependency.
module hazard_src_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    input  logic [REG_W-1:0] id_ex_rd_i,
    input  logic [REG_W-1:0] ex_mem_rd_i,
    output logic             m_id_ex_o,
    output logic             m_ex_mem_o
);
    logic live;

    assign live       = use_i && (src_i != '0);
    assign m_id_ex_o  = live && (src_i == id_ex_rd_i);
    assign m_ex_mem_o = live && (src_i == ex_mem_rd_i);
endmodule

module hazard_scoreboard #(
    parameter int REG_W        = 5,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 16,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] Rt,
    input  logic             UseRs,
    input  logic             UseRt,
    input  logic             Branch,
    input  logic             BranchNot,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic [REG_W-1:0] EX_MEM_RegisterRd,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             Sel,
    output logic             pipe_hold,
    output logic             IF_ID_Flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);
    localparam int NUM_SRC = 2;
    localparam int WAIT_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
    localparam bit BR_EN = (BRANCH_IN_ID != 0);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
    logic                flush_pend_q, flush_pend_d;
    logic                mem_err_q, mem_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Operand matching, one matcher per source register
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0][REG_W-1:0] src;
    logic [NUM_SRC-1:0]            src_use;
    logic [NUM_SRC-1:0]            m_id_ex, m_ex_mem;

    assign src     = {Rt, Rs};
    assign src_use = {UseRt, UseRs};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_src_match #(.REG_W(REG_W)) u_match (
            .src_i       (src[g]),
            .use_i       (src_use[g]),
            .id_ex_rd_i  (ID_EX_RegisterRd),
            .ex_mem_rd_i (EX_MEM_RegisterRd),
            .m_id_ex_o   (m_id_ex[g]),
            .m_ex_mem_o  (m_ex_mem[g])
        );
    end

    logic load_use, br_haz, data_haz;
    logic mem_access, hold;

    assign load_use = ID_EX_MemRead && (|m_id_ex);
    // An ID-resolved branch needs its operands now: it waits on any ALU
    // result still in EX and on a load still in MEM. With EX resolution the
    // normal forwarding paths cover it, so BR_EN masks the whole term.
    assign br_haz   = BR_EN && (Branch || BranchNot) &&
                      ((ID_EX_RegWrite && (|m_id_ex)) ||
                       (EX_MEM_MemRead && (|m_ex_mem)));
    assign data_haz = load_use || br_haz;

    // The freeze starts in the very cycle a slow access is first seen, not
    // one cycle later when the FSM has moved to MEM_WAIT.
    assign mem_access = EX_MEM_MemRead || EX_MEM_MemWrite;
    assign hold       = (state_q == MEM_WAIT) || (mem_access && !mem_ready);

    assign wait_inc = wait_cnt_q + WAIT_W'(1);

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_err_d    = 1'b0;
        flush_pend_d = flush_pend_q;
        stall_cnt_d  = stall_cnt_q;

        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        Sel         = 1'b1;
        pipe_hold   = 1'b0;
        IF_ID_Flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_access && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else if (wait_inc == TIMEOUT_V) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: state_d = RUN;
        endcase

        if (hold) begin
            // Freeze everything; the ID/EX contents stay valid, so no bubble.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            pipe_hold   = 1'b1;
            if (branch_taken) flush_pend_d = 1'b1;
        end else begin
            if (data_haz) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                Sel         = 1'b0;
            end
            if (branch_taken || flush_pend_q) begin
                // Flush wins over a stall: IF/ID is cleared rather than held.
                IF_ID_Flush  = 1'b1;
                IF_ID_Write  = 1'b0;
                flush_pend_d = 1'b0;
            end
        end

        if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

        // During reset the pipeline control is forced inactive.
        if (!rst) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            Sel         = 1'b0;
            pipe_hold   = 1'b0;
            IF_ID_Flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            mem_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_err_q    <= mem_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mem_err     = mem_err_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed bench. Two DUTs share all inputs:
//     u_a : BRANCH_IN_ID=1, CNT_W=16, MEM_TIMEOUT=4
//     u_b : BRANCH_IN_ID=0, CNT_W=2
//   Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int REG_W = 5;

    logic clk = 1'b0;
    logic rst;
    logic [REG_W-1:0] Rs, Rt, ID_EX_RegisterRd, EX_MEM_RegisterRd;
    logic UseRs, UseRt, Branch, BranchNot;
    logic ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic mem_ready, branch_taken;

    logic a_pcw, a_ifw, a_sel, a_hold, a_flush, a_err;
    logic [15:0] a_cnt;
    logic b_pcw, b_ifw, b_sel, b_hold, b_flush, b_err;
    logic [1:0] b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(REG_W), .BRANCH_IN_ID(1), .CNT_W(16), .MEM_TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst), .Rs(Rs), .Rt(Rt), .UseRs(UseRs), .UseRt(UseRt),
        .Branch(Branch), .BranchNot(BranchNot),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegisterRd(ID_EX_RegisterRd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .Sel(a_sel), .pipe_hold(a_hold),
        .IF_ID_Flush(a_flush), .mem_err(a_err), .stall_count(a_cnt)
    );

    hazard_scoreboard #(.REG_W(REG_W), .BRANCH_IN_ID(0), .CNT_W(2), .MEM_TIMEOUT(64)) u_b (
        .clk(clk), .rst(rst), .Rs(Rs), .Rt(Rt), .UseRs(UseRs), .UseRt(UseRt),
        .Branch(Branch), .BranchNot(BranchNot),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .ID_EX_RegisterRd(ID_EX_RegisterRd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .Sel(b_sel), .pipe_hold(b_hold),
        .IF_ID_Flush(b_flush), .mem_err(b_err), .stall_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // PCWrite, IF_ID_Write, Sel, pipe_hold, IF_ID_Flush of instance A
    task automatic chk_a(input string tag, input logic pcw, input logic ifw,
                         input logic sel, input logic hold, input logic flush);
        chk({tag, ".PCWrite"},     {31'b0, a_pcw},   {31'b0, pcw});
        chk({tag, ".IF_ID_Write"}, {31'b0, a_ifw},   {31'b0, ifw});
        chk({tag, ".Sel"},         {31'b0, a_sel},   {31'b0, sel});
        chk({tag, ".pipe_hold"},   {31'b0, a_hold},  {31'b0, hold});
        chk({tag, ".IF_ID_Flush"}, {31'b0, a_flush}, {31'b0, flush});
    endtask

    task automatic clr_in();
        Rs = '0; Rt = '0; UseRs = 0; UseRt = 0; Branch = 0; BranchNot = 0;
        ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegisterRd = '0;
        EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; EX_MEM_RegisterRd = '0;
        mem_ready = 0; branch_taken = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_in();
        rst = 0;
        #2;
        rst = 1;
    endtask

    initial begin
        rst = 0;
        clr_in();
        // ---------------- reset state ----------------
        #2;
        chk_a("rst", 0, 0, 0, 0, 0);
        chk("rst.stall_count", {16'b0, a_cnt}, 0);
        chk("rst.mem_err", {31'b0, a_err}, 0);
        branch_taken = 1;
        #1;
        chk("rst.flush_masked", {31'b0, a_flush}, 0);

        step(); clr_in(); rst = 1;
        #1;
        chk_a("idle", 1, 1, 1, 0, 0);

        // ---------------- load-use ----------------
        step();
        ID_EX_MemRead = 1; ID_EX_RegisterRd = 5; Rs = 5; UseRs = 1;
        #1;
        chk_a("loaduse", 0, 0, 0, 0, 0);
        step(); clr_in(); #1;
        chk_a("loaduse.after", 1, 1, 1, 0, 0);
        chk("loaduse.count", {16'b0, a_cnt}, 1);

        // zero register never hazards
        step();
        ID_EX_MemRead = 1; ID_EX_RegisterRd = 0; Rs = 0; UseRs = 1;
        #1;
        chk_a("zero_reg", 1, 1, 1, 0, 0);
        // Rt match ignored without UseRt, honoured with it
        step(); clr_in();
        ID_EX_MemRead = 1; ID_EX_RegisterRd = 9; Rt = 9; UseRt = 0;
        #1;
        chk("rt_unused.PCWrite", {31'b0, a_pcw}, 1);
        step(); UseRt = 1; #1;
        chk("rt_used.Sel", {31'b0, a_sel}, 0);
        step(); clr_in(); #1;
        chk("rt.count", {16'b0, a_cnt}, 2);

        // ---------------- memory wait ----------------
        do_reset();
        step(); EX_MEM_MemRead = 1; mem_ready = 0; #1;
        chk_a("mw.c1", 0, 0, 1, 1, 0);
        step(); #1; chk_a("mw.c2", 0, 0, 1, 1, 0);
        step(); #1; chk_a("mw.c3", 0, 0, 1, 1, 0);
        step(); mem_ready = 1; #1;
        chk_a("mw.c4", 0, 0, 1, 1, 0);
        step(); EX_MEM_MemRead = 0; mem_ready = 0; #1;
        chk_a("mw.run", 1, 1, 1, 0, 0);
        chk("mw.count", {16'b0, a_cnt}, 4);

        // ---------------- deferred flush ----------------
        do_reset();
        step(); EX_MEM_MemRead = 1; mem_ready = 0; #1;
        chk("df.c1.flush", {31'b0, a_flush}, 0);
        step(); branch_taken = 1; #1;
        chk_a("df.c2", 0, 0, 1, 1, 0);
        step(); branch_taken = 0; mem_ready = 1; #1;
        chk_a("df.c3", 0, 0, 1, 1, 0);
        step(); EX_MEM_MemRead = 0; mem_ready = 0; #1;
        chk_a("df.flush", 1, 0, 1, 0, 1);
        step(); #1;
        chk_a("df.cleared", 1, 1, 1, 0, 0);

        // immediate flush with simultaneous load-use: flush wins
        step();
        branch_taken = 1; ID_EX_MemRead = 1; ID_EX_RegisterRd = 4; Rs = 4; UseRs = 1;
        #1;
        chk_a("flush_haz", 0, 0, 0, 0, 1);
        step(); clr_in(); #1;
        chk_a("flush_haz.after", 1, 1, 1, 0, 0);

        // ---------------- timeout (MEM_TIMEOUT=4) ----------------
        do_reset();
        step(); EX_MEM_MemWrite = 1; mem_ready = 0; #1;
        chk("to.c1.hold", {31'b0, a_hold}, 1);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            chk($sformatf("to.wait%0d.hold", i), {31'b0, a_hold}, 1);
            chk($sformatf("to.wait%0d.err", i), {31'b0, a_err}, 0);
        end
        step(); EX_MEM_MemWrite = 0; #1;
        chk("to.err_pulse", {31'b0, a_err}, 1);
        chk_a("to.run", 1, 1, 1, 0, 0);
        step(); #1;
        chk("to.err_cleared", {31'b0, a_err}, 0);

        // ---------------- reset during MEM_WAIT ----------------
        do_reset();
        step(); EX_MEM_MemRead = 1; mem_ready = 0; #1;
        step(); #1;
        chk("rmw.hold_before", {31'b0, a_hold}, 1);
        step(); rst = 0; #1;
        chk_a("rmw.in_reset", 0, 0, 0, 0, 0);
        step(); rst = 1; EX_MEM_MemRead = 0; #1;
        chk_a("rmw.released", 1, 1, 1, 0, 0);
        chk("rmw.err0", {31'b0, a_err}, 0);
        step(); #1;
        chk("rmw.err1", {31'b0, a_err}, 0);

        // ---------------- branch mode ----------------
        do_reset();
        step();
        Branch = 1; Rs = 7; UseRs = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 7;
        #1;
        chk("br.id.PCWrite", {31'b0, a_pcw}, 0);
        chk("br.id.Sel", {31'b0, a_sel}, 0);
        chk("br.ex.PCWrite", {31'b0, b_pcw}, 1);
        chk("br.ex.Sel", {31'b0, b_sel}, 1);
        step(); clr_in();
        BranchNot = 1; Rt = 3; UseRt = 1; EX_MEM_MemRead = 1;
        EX_MEM_RegisterRd = 3; mem_ready = 1;
        #1;
        chk_a("bne.memload", 0, 0, 0, 0, 0);
        chk("bne.ex.PCWrite", {31'b0, b_pcw}, 1);
        step(); clr_in();
        Rs = 7; UseRs = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 7;
        #1;
        chk("nobranch.PCWrite", {31'b0, a_pcw}, 1);

        // ---------------- saturation ----------------
        do_reset();
        step();
        ID_EX_MemRead = 1; ID_EX_RegisterRd = 2; Rs = 2; UseRs = 1;
        for (int k = 1; k <= 5; k++) begin
            step(); #1;
            chk($sformatf("sat.a%0d", k), {16'b0, a_cnt}, k);
            chk($sformatf("sat.b%0d", k), {30'b0, b_cnt}, (k > 3) ? 3 : k);
        end
        step(); clr_in(); #1;
        chk("sat.b_hold", {30'b0, b_cnt}, 3);
        chk("sat.a_final", {16'b0, a_cnt}, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
